// File: rtl/ex_stage_mc.sv
// Execute stage: sequences a multi-cycle ALU, issues aligned data-SRAM requests
// and presents its in-flight instruction to ID for forwarding and load-use stalls.
module ex_stage_mc #(
    parameter int ALU_OP_W  = 19,
    parameter int RF_ADDR_W = 5,
    parameter int PC_W      = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ds_to_es_valid,
    output logic                 es_allowin,
    input  logic [ALU_OP_W-1:0]  ds_alu_op,
    input  logic [31:0]          ds_alu_src1,
    input  logic [31:0]          ds_alu_src2,
    input  logic [31:0]          ds_rkd_value,
    input  logic [PC_W-1:0]      ds_pc,
    input  logic                 ds_mem_we,
    input  logic                 ds_res_from_mem,
    input  logic                 ds_mem_unsigned,
    input  logic [1:0]           ds_mem_size,
    input  logic                 ds_rf_we,
    input  logic [RF_ADDR_W-1:0] ds_rf_waddr,
    input  logic                 flush,
    output logic                 alu_start,
    output logic                 alu_cancel,
    output logic [ALU_OP_W-1:0]  alu_op,
    output logic [31:0]          alu_src1,
    output logic [31:0]          alu_src2,
    input  logic [31:0]          alu_result,
    input  logic                 alu_done,
    output logic                 data_sram_req,
    output logic                 data_sram_wr,
    output logic [1:0]           data_sram_size,
    output logic [3:0]           data_sram_wstrb,
    output logic [31:0]          data_sram_addr,
    output logic [31:0]          data_sram_wdata,
    input  logic                 data_sram_addr_ok,
    input  logic                 ms_allowin,
    output logic                 es_to_ms_valid,
    output logic [PC_W-1:0]      es_pc,
    output logic [31:0]          es_result,
    output logic                 es_rf_we,
    output logic                 es_res_from_mem,
    output logic                 es_mem_unsigned,
    output logic                 es_ale,
    output logic [1:0]           es_mem_size,
    output logic [1:0]           es_byte_off,
    output logic [RF_ADDR_W-1:0] es_rf_waddr,
    output logic                 es_fwd_valid
);

    typedef enum logic [1:0] {IDLE, ALU, MEM, DONE} state_t;

    state_t                state_reg, state_next;
    logic [ALU_OP_W-1:0]   op_reg;
    logic [31:0]           src1_reg, src2_reg, rkd_reg, result_reg;
    logic [PC_W-1:0]       pc_reg;
    logic                  mem_we_reg, res_from_mem_reg, mem_unsigned_reg;
    logic [1:0]            mem_size_reg;
    logic                  rf_we_reg;
    logic [RF_ADDR_W-1:0]  rf_waddr_reg;
    logic                  ale_reg;
    logic                  first_reg;

    logic capture;
    logic is_mem;
    logic misalign;

    assign es_allowin = (state_reg == IDLE) || (state_reg == DONE && ms_allowin);
    assign capture    = ds_to_es_valid && es_allowin && !flush;
    assign is_mem     = mem_we_reg || res_from_mem_reg;
    // The access address is the ALU result, so alignment is judged as it returns.
    assign misalign   = (mem_size_reg == 2'd1 && alu_result[0]) ||
                        (mem_size_reg[1] && alu_result[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (capture) state_next = ALU;
            ALU: begin
                if (alu_done) begin
                    state_next = (is_mem && !misalign) ? MEM : DONE;
                end
            end
            MEM:  if (data_sram_addr_ok) state_next = DONE;
            DONE: if (ms_allowin) state_next = capture ? ALU : IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_reg           <= '0;
            src1_reg         <= '0;
            src2_reg         <= '0;
            rkd_reg          <= '0;
            pc_reg           <= '0;
            result_reg       <= '0;
            mem_we_reg       <= 1'b0;
            res_from_mem_reg <= 1'b0;
            mem_unsigned_reg <= 1'b0;
            mem_size_reg     <= 2'd0;
            rf_we_reg        <= 1'b0;
            rf_waddr_reg     <= '0;
            ale_reg          <= 1'b0;
            first_reg        <= 1'b0;
        end else begin
            first_reg <= capture;
            if (capture) begin
                op_reg           <= ds_alu_op;
                src1_reg         <= ds_alu_src1;
                src2_reg         <= ds_alu_src2;
                rkd_reg          <= ds_rkd_value;
                pc_reg           <= ds_pc;
                result_reg       <= '0;
                mem_we_reg       <= ds_mem_we;
                res_from_mem_reg <= ds_res_from_mem;
                mem_unsigned_reg <= ds_mem_unsigned;
                mem_size_reg     <= ds_mem_size;
                rf_we_reg        <= ds_rf_we;
                rf_waddr_reg     <= ds_rf_waddr;
                ale_reg          <= 1'b0;
            end else if (state_reg == ALU && alu_done && !flush) begin
                result_reg <= alu_result;
                ale_reg    <= is_mem && misalign;
            end
        end
    end

    assign alu_start  = (state_reg == ALU) && first_reg;
    assign alu_cancel = flush && (state_reg == ALU);
    assign alu_op     = op_reg;
    assign alu_src1   = src1_reg;
    assign alu_src2   = src2_reg;

    assign data_sram_req  = (state_reg == MEM) && !flush;
    assign data_sram_wr   = mem_we_reg;
    assign data_sram_size = mem_size_reg;
    assign data_sram_addr = result_reg;

    // Per-lane strobe and write data: narrow stores are replicated across lanes.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        logic hit;
        assign hit = (mem_size_reg == 2'd0) ? (result_reg[1:0] == LANE) :
                     (mem_size_reg == 2'd1) ? (result_reg[1] == LANE[1]) : 1'b1;
        assign data_sram_wstrb[gi] = mem_we_reg && hit;
        assign data_sram_wdata[8*gi +: 8] =
            (mem_size_reg == 2'd0) ? rkd_reg[7:0] :
            (mem_size_reg == 2'd1) ? rkd_reg[8*(gi%2) +: 8] : rkd_reg[8*gi +: 8];
    end

    assign es_to_ms_valid  = (state_reg == DONE);
    assign es_pc           = pc_reg;
    assign es_result       = result_reg;
    assign es_rf_we        = rf_we_reg && (state_reg != IDLE);
    assign es_res_from_mem = res_from_mem_reg && (state_reg != IDLE);
    assign es_mem_unsigned = mem_unsigned_reg;
    assign es_ale          = ale_reg;
    assign es_mem_size     = mem_size_reg;
    assign es_byte_off     = result_reg[1:0];
    assign es_rf_waddr     = rf_waddr_reg;
    assign es_fwd_valid    = rf_we_reg && !res_from_mem_reg && (state_reg == DONE);

endmodule

// File: doc/ex_stage_mc.md
# ex_stage_mc

Parametrised execute stage for the five-stage LoongArch pipeline, sitting between ID and MEM. Drives an external multi-cycle ALU through a start/done handshake, issues byte/half/word loads and stores to the data SRAM over a req/addr_ok handshake, and generates byte strobes and replicated write data. Supports a pipeline flush and reports misaligned accesses to MEM. Provides a forwarding/load-use view of its in-flight instruction to ID.

## Interface
- ALU_OP_W, 19, width of ALU opcode vector
- RF_ADDR_W, 5, register-file address width
- PC_W, 32, PC width; data and address paths are fixed at 32 bits
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- ds_to_es_valid  in  1  / es_allowin  out  1  ID→EX handshake
- ds_alu_op  in  ALU_OP_W; ds_alu_src1, ds_alu_src2, ds_rkd_value  in  32; ds_pc  in  PC_W
- ds_mem_we, ds_res_from_mem, ds_mem_unsigned  in  1; ds_mem_size  in  2  (0 byte, 1 half, 2 word)
- ds_rf_we  in  1; ds_rf_waddr  in  RF_ADDR_W
- flush  in  1  kill the instruction held in EX
- alu_start  out  1; alu_cancel  out  1; alu_op  out  ALU_OP_W; alu_src1, alu_src2  out  32; alu_result  in  32; alu_done  in  1
- data_sram_req, data_sram_wr  out  1; data_sram_size  out  2; data_sram_wstrb  out  4; data_sram_addr, data_sram_wdata  out  32; data_sram_addr_ok  in  1
- ms_allowin  in  1; es_to_ms_valid  out  1
- es_pc  out  PC_W; es_result  out  32; es_rf_we, es_res_from_mem, es_mem_unsigned, es_ale  out  1; es_mem_size, es_byte_off  out  2; es_rf_waddr  out  RF_ADDR_W
- es_fwd_valid  out  1  es_result is final and forwardable

## Operation
- States: IDLE, ALU, MEM, DONE. Reset → IDLE; all registered outputs 0.
- es_allowin = (state==IDLE) | (state==DONE & ms_allowin). Capture on ds_to_es_valid & es_allowin & !flush → ALU; a DONE exit with no new input → IDLE.
- ALU: alu_start=1 on the first ALU cycle only. alu_op/alu_src* are held stable throughout. On alu_done, register alu_result into es_result. alu_done may arrive in the same cycle as alu_start.
- After done: a memory op (mem_we | res_from_mem) → MEM if aligned, else DONE with es_ale=1. A non-memory op → DONE.
- Misaligned means half with addr[0]=1, or word with addr[1:0]≠0. A misaligned access never raises data_sram_req.
- MEM: data_sram_req = !flush, held until data_sram_addr_ok. addr = es_result. wr = mem_we. size = mem_size. On addr_ok → DONE.
- wstrb is 4'b0000 for loads. For stores:
  - byte: 4'b0001<<off, wdata = {4{rkd[7:0]}}
  - half: 4'b0011<<off, wdata = {2{rkd[15:0]}}
  - word: 4'b1111, wdata = rkd
- es_byte_off = es_result[1:0].
- DONE: es_to_ms_valid=1. es_fwd_valid = es_rf_we & !es_res_from_mem & state==DONE.
- es_rf_we and es_res_from_mem are valid in every non-IDLE state, so ID can detect load-use and stall. In IDLE both are forced to 0.
- flush: next state IDLE regardless of state. Any capture in that cycle is suppressed. alu_cancel = flush & state==ALU. data_sram_req is masked combinationally, so no request is accepted in a flush cycle.

## Timing
- Capture at edge T: ALU state in cycle T+1, with alu_start=1 in T+1.
- Single-cycle ALU op, no memory: done in T+1, DONE (es_to_ms_valid) in T+2.
- Aligned load/store with immediate addr_ok: MEM in T+2, DONE in T+3. Each addr_ok wait cycle adds 1.
- Back-to-back: in a DONE cycle with ms_allowin=1 and ds_to_es_valid=1, the next instruction is captured and the stage is in ALU next cycle. There is no bubble on exit.
- DONE with ms_allowin=0: all outputs are held and es_allowin=0.
- Reset asserted in any state: IDLE next cycle, regardless of flush or other inputs.

## Test plan
- add, src1=5, src2=7, alu_done in the start cycle → alu_start for 1 cycle, es_to_ms_valid at T+2, es_result=12, es_fwd_valid=1.
- st.b, addr 0x1003, rkd=0xAABBCCDD, addr_ok delayed 2 cycles → req held 3 cycles, wstrb=4'b1000, wdata=0xDDDDDDDD, size=0, DONE at T+5.
- ld.h at addr 0x2001 → no data_sram_req, DONE at T+2 with es_ale=1, es_res_from_mem=1, es_byte_off=1.
- Div with alu_done 10 cycles after start, flush asserted on cycle 4 → alu_cancel=1 for that cycle, IDLE next, es_to_ms_valid never set, es_allowin=1.
- ld.w, addr 0x100, ms_allowin=0 for 3 cycles in DONE, ds_to_es_valid=1 → outputs stable, es_allowin=0. When ms_allowin rises: handoff plus capture in the same cycle, ALU state next cycle.
- flush and addr_ok both high in MEM → data_sram_req=0, state IDLE next.
